// File: rtl/kart_pkg.sv
// Shared types and screen-geometry constants for the kart renderer's projection path.
package kart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MULT  = 3'd1,
        ROT   = 3'd2,
        DIV_H = 3'd3,
        DIV_V = 3'd4,
        OUT   = 3'd5
    } proj_state_t;

    localparam int VIEW_H_MIN    = 512;
    localparam int VIEW_H_MAX    = 1023;
    localparam int VIEW_CENTER_H = 767;
    localparam int HORIZON_V     = 512;
    localparam int VIEW_V_MAX    = 767;
    localparam int TRIG_SHIFT    = 9;

    function automatic logic [7:0] sat_u8(input logic [31:0] val);
        return (val > 32'd255) ? 8'hFF : val[7:0];
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses DIV_W+1 cycles after start.
module serial_divider #(
    parameter int DIV_W = 20
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [DIV_W-1:0] num_in,
    input  logic [DIV_W-1:0] den_in,
    output logic             done_out,
    output logic [DIV_W-1:0] quo_out
);
    localparam int CNT_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] quo_q, quo_d, rem_q, rem_d, den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [DIV_W:0]   rem_sh_s;

    // Shift-subtract step; a zero divisor always subtracts, giving an all-ones quotient.
    always_comb begin
        quo_d    = quo_q;
        rem_d    = rem_q;
        den_d    = den_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        rem_sh_s = {rem_q, quo_q[DIV_W-1]};
        if (start_in) begin
            quo_d = num_in;
            rem_d = '0;
            den_d = den_in;
            cnt_d = CNT_W'(DIV_W);
        end else if (cnt_q != '0) begin
            if (rem_sh_s >= {1'b0, den_q}) begin
                rem_d = DIV_W'(rem_sh_s - {1'b0, den_q});
                quo_d = {quo_q[DIV_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh_s[DIV_W-1:0];
                quo_d = {quo_q[DIV_W-2:0], 1'b0};
            end
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end else begin
            done_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done_out = done_q;
    assign quo_out  = quo_q;

endmodule

// File: rtl/opponent_projector.sv
// Projects the opponent's world position onto the perspective viewport once per frame.
// Build option PROJ_ROUND_EN: round the heading rotation to nearest instead of flooring.
module opponent_projector
    import kart_pkg::*;
#(
    parameter int DIV_W    = 20,
    parameter int NEAR_MIN = 16,
    parameter int DEPTH_K  = 25600,
    parameter int SCALE_K  = 6400
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic signed [10:0] cos_in,
    input  logic signed [10:0] sin_in,
    input  logic [10:0]        player_x,
    input  logic [10:0]        player_y,
    input  logic [10:0]        opponent_x,
    input  logic [10:0]        opponent_y,
    output logic               busy_out,
    output logic               done_out,
    output logic               visible_out,
    output logic [10:0]        hcount_out,
    output logic [9:0]         vcount_out,
    output logic [7:0]         scale_out
);
    localparam int SCALE_SHIFT = $clog2(DEPTH_K / SCALE_K);
    localparam int Q1_MAX      = 1023;
`ifdef PROJ_ROUND_EN
    localparam logic signed [23:0] ROUND_BIAS = 24'sd256;
`else
    localparam logic signed [23:0] ROUND_BIAS = 24'sd0;
`endif

    proj_state_t              state_q, state_d;
    logic signed [10:0]       cos_q, cos_d, sin_q, sin_d;
    logic [10:0]              px_q, px_d, py_q, py_d, ox_q, ox_d, oy_q, oy_d;
    logic signed [22:0]       p_xc_q, p_xc_d, p_ys_q, p_ys_d, p_xs_q, p_xs_d, p_yc_q, p_yc_d;
    logic                     cx_neg_q, cx_neg_d;
    logic signed [14:0]       cy_q, cy_d;
    logic [DIV_W-1:0]         q1_q, q1_d, div_num_q, div_num_d, div_den_q, div_den_d;
    logic                     div_start_q, div_start_d;
    logic                     busy_q, busy_d, done_q, done_d, vis_q, vis_d;
    logic [10:0]              h_q, h_d;
    logic [9:0]               v_q, v_d;
    logic [7:0]               s_q, s_d;

    logic signed [11:0]       dx_s, dy_s;
    logic signed [14:0]       cx_s, cy_s;
    logic [14:0]              cx_abs_s;
    logic [22:0]              num_wide_s;
    logic signed [11:0]       h_s;
    logic                     h_ok_s;
    logic                     div_done_s;
    logic [DIV_W-1:0]         div_quo_s;

    serial_divider #(.DIV_W(DIV_W)) u_div (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .start_in (div_start_q),
        .num_in   (div_num_q),
        .den_in   (div_den_q),
        .done_out (div_done_s),
        .quo_out  (div_quo_s)
    );

    // Rotation into view space and horizontal placement from the captured quotient.
    always_comb begin
        dx_s       = $signed({1'b0, ox_q}) - $signed({1'b0, px_q});
        dy_s       = $signed({1'b0, oy_q}) - $signed({1'b0, py_q});
        cx_s       = 15'((24'(p_xc_q) + 24'(p_ys_q) + ROUND_BIAS) >>> TRIG_SHIFT);
        cy_s       = 15'((24'(p_yc_q) - 24'(p_xs_q) + ROUND_BIAS) >>> TRIG_SHIFT);
        cx_abs_s   = cx_s[14] ? 15'(-cx_s) : 15'(cx_s);
        num_wide_s = {cx_abs_s, 8'h00};
        h_s        = cx_neg_q ? 12'(VIEW_CENTER_H) + $signed({2'b00, q1_q[9:0]})
                              : 12'(VIEW_CENTER_H) - $signed({2'b00, q1_q[9:0]});
        h_ok_s     = (q1_q <= DIV_W'(Q1_MAX)) && (h_s >= 12'(VIEW_H_MIN)) && (h_s <= 12'(VIEW_H_MAX));
    end

    // Sequencer next-state; results only change on the cycle that raises done.
    always_comb begin
        state_d     = state_q;
        cos_d       = cos_q;
        sin_d       = sin_q;
        px_d        = px_q;
        py_d        = py_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        p_xc_d      = p_xc_q;
        p_ys_d      = p_ys_q;
        p_xs_d      = p_xs_q;
        p_yc_d      = p_yc_q;
        cx_neg_d    = cx_neg_q;
        cy_d        = cy_q;
        q1_d        = q1_q;
        div_num_d   = div_num_q;
        div_den_d   = div_den_q;
        div_start_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        vis_d       = vis_q;
        h_d         = h_q;
        v_d         = v_q;
        s_d         = s_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    cos_d   = cos_in;
                    sin_d   = sin_in;
                    px_d    = player_x;
                    py_d    = player_y;
                    ox_d    = opponent_x;
                    oy_d    = opponent_y;
                    busy_d  = 1'b1;
                    state_d = MULT;
                end else begin
                    state_d = IDLE;
                end
            end
            MULT: begin
                p_xc_d  = 23'(dx_s) * 23'(cos_q);
                p_ys_d  = 23'(dy_s) * 23'(sin_q);
                p_xs_d  = 23'(dx_s) * 23'(sin_q);
                p_yc_d  = 23'(dy_s) * 23'(cos_q);
                state_d = ROT;
            end
            ROT: begin
                cx_neg_d = cx_s[14];
                cy_d     = cy_s;
                if (cy_s < $signed(15'(NEAR_MIN))) begin
                    vis_d   = 1'b0;
                    h_d     = 11'd0;
                    v_d     = 10'd0;
                    s_d     = 8'd0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = OUT;
                end else begin
                    // |cx|*256 beyond the divider width can only land off-screen.
                    div_num_d   = ((num_wide_s >> DIV_W) != 23'd0) ? '1 : DIV_W'(num_wide_s);
                    div_den_d   = DIV_W'($unsigned(cy_s));
                    div_start_d = 1'b1;
                    state_d     = DIV_H;
                end
            end
            DIV_H: begin
                if (div_done_s) begin
                    q1_d        = div_quo_s;
                    div_num_d   = DIV_W'(DEPTH_K);
                    div_den_d   = DIV_W'($unsigned(cy_q));
                    div_start_d = 1'b1;
                    state_d     = DIV_V;
                end else begin
                    state_d = DIV_H;
                end
            end
            DIV_V: begin
                if (div_done_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = OUT;
                    if (h_ok_s) begin
                        vis_d = 1'b1;
                        h_d   = 11'(h_s);
                        v_d   = (div_quo_s > DIV_W'(VIEW_V_MAX - HORIZON_V)) ? 10'(VIEW_V_MAX)
                                : 10'(HORIZON_V) + 10'(div_quo_s);
                        s_d   = sat_u8(32'(div_quo_s >> SCALE_SHIFT));
                    end else begin
                        vis_d = 1'b0;
                        h_d   = 11'd0;
                        v_d   = 10'd0;
                        s_d   = 8'd0;
                    end
                end else begin
                    state_d = DIV_V;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All sequencer, datapath and result registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            cos_q       <= '0;
            sin_q       <= '0;
            px_q        <= '0;
            py_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            p_xc_q      <= '0;
            p_ys_q      <= '0;
            p_xs_q      <= '0;
            p_yc_q      <= '0;
            cx_neg_q    <= 1'b0;
            cy_q        <= '0;
            q1_q        <= '0;
            div_num_q   <= '0;
            div_den_q   <= '0;
            div_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vis_q       <= 1'b0;
            h_q         <= '0;
            v_q         <= '0;
            s_q         <= '0;
        end else begin
            state_q     <= state_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            px_q        <= px_d;
            py_q        <= py_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            p_xc_q      <= p_xc_d;
            p_ys_q      <= p_ys_d;
            p_xs_q      <= p_xs_d;
            p_yc_q      <= p_yc_d;
            cx_neg_q    <= cx_neg_d;
            cy_q        <= cy_d;
            q1_q        <= q1_d;
            div_num_q   <= div_num_d;
            div_den_q   <= div_den_d;
            div_start_q <= div_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vis_q       <= vis_d;
            h_q         <= h_d;
            v_q         <= v_d;
            s_q         <= s_d;
        end
    end

    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign visible_out = vis_q;
    assign hcount_out  = h_q;
    assign vcount_out  = v_q;
    assign scale_out   = s_q;

endmodule

// File: doc/opponent_projector.md
Name: opponent_projector

Overview:
- Inverse of the forward-view mapping: converts the opponent's world position into screen coordinates and a sprite scale for the perspective viewport.
- Takes player pose (position plus cos/sin of heading from the shared trig ROMs) and opponent position.
- Produces the billboard anchor (hcount/vcount), a scale, and a visibility flag.
- Runs once per frame, started by the frame sequencer.
- Multi-cycle FSM sharing one serial divider.

Parameters:
- DIV_W, 20, divider numerator/quotient width; sets latency.
- NEAR_MIN, 16, minimum rotated depth cy (world units) considered visible.
- DEPTH_K, 25600, row numerator: vcount = 512 + DEPTH_K/cy.
- SCALE_K, 6400, scale numerator: scale = SCALE_K/cy.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- start_in  input  1  one-cycle request; accepted only in IDLE
- cos_in  input  11  signed cos(heading), scaled by 512
- sin_in  input  11  signed sin(heading), scaled by 512
- player_x  input  11  player world x
- player_y  input  11  player world y
- opponent_x  input  11  opponent world x
- opponent_y  input  11  opponent world y
- busy_out  output  1  high from the cycle after acceptance until done_out
- done_out  output  1  one-cycle pulse; result outputs valid
- visible_out  output  1  opponent lies inside the viewport
- hcount_out  output  11  screen column, range 512..1023
- vcount_out  output  10  screen row, range 512..767
- scale_out  output  8  sprite scale, saturated at 255

Behaviour:
- Reset (rst_in low, async): state IDLE; all outputs 0. Reset mid-operation aborts the request; no done_out is produced.
- Cycle 0 (IDLE, start_in=1): all inputs are registered. start_in while busy is ignored.
- MULT (cycle 1):
  - dx = opponent_x − player_x, 12-bit signed; dy likewise.
  - Four products are registered: dx·cos, dy·sin, dx·sin, dy·cos.
- ROT (cycle 2):
  - cx = (dx·cos + dy·sin) >>> 9; cy = (dy·cos − dx·sin) >>> 9.
  - Shift is arithmetic, i.e. floor.
  - If cy < NEAR_MIN, go to OUT with visible=0; done_out is asserted at cycle 3.
- DIV_H:
  - Divider computes q1 = (|cx|·256) / cy, unsigned.
  - Start is pulsed at cycle 3; the quotient is returned DIV_W+1 cycles later.
- DIV_V: divider computes q2 = DEPTH_K / cy.
- OUT (cycle 2·DIV_W+7; 47 at defaults), registered results:
  - hoff = sign(cx)·q1; h = 767 − hoff.
  - visible = (q1 ≤ 1023) && 512 ≤ h ≤ 1023. Otherwise visible=0 and hcount_out=0.
  - vcount_out = min(512+q2, 767).
  - scale_out = min(SCALE_K/cy, 255). Computed as q2·SCALE_K/DEPTH_K; at defaults this is q2>>2.
  - done_out=1 for one cycle; return to IDLE.
- Results hold until the next done_out. When visible=0, hcount/vcount/scale are 0.
- Intermediate widths: products 23 bits signed; rotated sums 24 bits before the shift; all clamps are applied at OUT.

Optional Feature:
- Macro: PROJ_ROUND_EN.
  - Defined: the ROT shift rounds to nearest by adding 256 before >>> 9.
  - Undefined: floor truncation.
- Latency is identical in both builds.

Decomposition:
- Package kart_pkg holds:
  - state enum proj_state_t {IDLE, MULT, ROT, DIV_H, DIV_V, OUT}
  - constants VIEW_H_MIN=512, VIEW_H_MAX=1023, VIEW_CENTER_H=767, HORIZON_V=512, VIEW_V_MAX=767, TRIG_SHIFT=9
- Sub-module serial_divider (parameter DIV_W):
  - Restoring divider, one bit per cycle.
  - Handshake: start/done; latency DIV_W+1 cycles.
  - Divide-by-zero returns all-ones.

Test Plan:
- Straight ahead: cos=512, sin=0, player (1000,1000), opponent (1000,1200) → cy=200; done_out at cycle 47; visible=1, h=767, v=640, scale=32.
- Lateral offset: same pose, opponent (1100,1200) → cx=100, q1=128; h=639, v=640, scale=32, visible=1.
- Behind / near: opponent (1000,900) → cy=−100; done_out at cycle 3, visible=0, all results 0. Also start_in asserted at cycle 1 is ignored and busy_out stays 1 until done_out.
- Off-screen: opponent (1300,1100) → cx=300, cy=100, h=−1; visible=0 after the full 47 cycles.
- Rotated heading: cos=0, sin=512, player (1000,1000), opponent (800,1000) → cy=200, cx=0; h=767, v=640. Then cos=511, sin=0, opponent (1000,1200) → cy=199 without PROJ_ROUND_EN, cy=200 with it.
- Reset: drive rst_in low at cycle 10 of a request → outputs 0 immediately, no done_out. A new start after release completes normally.
